// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - opcodes, instruction field positions, FSM states and sign-extend helper for exec_unit
package exec_pkg;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_LI   = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_JAL  = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_NOT  = 4'hF;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int RA_MSB  = 3;
  localparam int RA_LSB  = 2;
  localparam int RB_MSB  = 1;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } exec_state_t;

  function automatic logic [7:0] sext4(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction

endpackage

// File: rtl/data_mem_sp.sv
// rtl/data_mem_sp.sv - 1-write/1-read synchronous data RAM with registered read
// Ports: clk; we/waddr/wdata write port; raddr in, rdata registered out.
// Contents are not reset; a read of the address written on the same edge returns the old data.
module data_mem_sp #(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [MEM_AW-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute/memory stage of the 8-bit accumulator CPU
// Ports: clk, rst_n; valid_in/ready handshake with instr, pc and register operands
// (ra_data, rb_data, r0_data, sp_data) read via ra_addr/rb_addr; result pulse valid_out
// with reg_we/reg_waddr/reg_wdata, pc_next, overflow, halt.
module exec_unit
  import exec_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  output logic       ready,
  input  logic [7:0] instr,
  input  logic [7:0] pc,
  output logic [1:0] ra_addr,
  output logic [1:0] rb_addr,
  input  logic [7:0] ra_data,
  input  logic [7:0] rb_data,
  input  logic [7:0] r0_data,
  input  logic [7:0] sp_data,
  output logic       valid_out,
  output logic       reg_we,
  output logic [1:0] reg_waddr,
  output logic [7:0] reg_wdata,
  output logic [7:0] pc_next,
  output logic       overflow,
  output logic       halt
);

  exec_state_t state, state_nxt;

  logic [7:0] instr_q, pc_q, ra_q, rb_q, r0_q, sp_q;
  logic [3:0] op_f, imm_f;
  logic [1:0] ra_f;
  logic       accept;

  assign ra_addr = instr[RA_MSB:RA_LSB];
  assign rb_addr = instr[RB_MSB:RB_LSB];
  assign ready   = (state == ST_IDLE);
  assign accept  = valid_in & ready;

  assign op_f  = instr_q[OP_MSB:OP_LSB];
  assign ra_f  = instr_q[RA_MSB:RA_LSB];
  assign imm_f = instr_q[IMM_MSB:IMM_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands are sampled once at accept so the register file may move on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      r0_q    <= '0;
      sp_q    <= '0;
    end else if (accept) begin
      instr_q <= instr;
      pc_q    <= pc;
      ra_q    <= ra_data;
      rb_q    <= rb_data;
      r0_q    <= r0_data;
      sp_q    <= sp_data;
    end
  end

  logic [7:0] pc_inc, sum, diff, sp_inc, sp_dec, jmp_target, br_target;

  assign pc_inc     = pc_q + 8'd1;
  assign sum        = ra_q + rb_q;
  assign diff       = ra_q - rb_q;
  assign sp_inc     = sp_q + 8'd1;
  assign sp_dec     = sp_q - 8'd1;
  assign jmp_target = pc_inc + sext4(imm_f);
  assign br_target  = pc_inc + r0_q;

  logic       e_we, e_ovf, e_halt, e_ld, e_ret;
  logic [1:0] e_waddr;
  logic [7:0] e_wdata, e_pc;
  logic       mem_we;
  logic [7:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;

  always_comb begin
    e_we      = 1'b0;
    e_waddr   = ra_f;
    e_wdata   = 8'h00;
    e_pc      = pc_inc;
    e_ovf     = 1'b0;
    e_halt    = 1'b0;
    e_ld      = 1'b0;
    e_ret     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = rb_q;
    mem_wdata = ra_q;
    mem_raddr = rb_q;
    case (op_f)
      OP_HALT: begin
        e_halt = 1'b1;
        e_pc   = pc_q;
      end
      OP_ADD: begin
        e_we    = 1'b1;
        e_wdata = sum;
        // Same-signed operands producing a result of the other sign.
        e_ovf   = (ra_q[7] == rb_q[7]) && (sum[7] != ra_q[7]);
      end
      OP_SUB: begin
        e_we    = 1'b1;
        e_wdata = diff;
        e_ovf   = (ra_q[7] != rb_q[7]) && (diff[7] != ra_q[7]);
      end
      OP_AND: begin e_we = 1'b1; e_wdata = ra_q & rb_q; end
      OP_OR:  begin e_we = 1'b1; e_wdata = ra_q | rb_q; end
      OP_XOR: begin e_we = 1'b1; e_wdata = ra_q ^ rb_q; end
      OP_SLT: begin
        e_we    = 1'b1;
        e_wdata = ($signed(ra_q) < $signed(rb_q)) ? 8'd1 : 8'd0;
      end
      OP_LI: begin
        e_we    = 1'b1;
        e_waddr = 2'd0;
        e_wdata = {4'b0000, imm_f};
      end
      OP_J: e_pc = jmp_target;
      OP_JAL: begin
        mem_we    = 1'b1;
        mem_waddr = sp_q;
        mem_wdata = pc_inc;
        e_we      = 1'b1;
        e_waddr   = 2'd3;
        e_wdata   = sp_dec;
        e_pc      = jmp_target;
      end
      OP_LW: begin
        e_we = 1'b1;
        e_ld = 1'b1;
      end
      OP_SW: mem_we = 1'b1;
      OP_BEQ: if (ra_q == rb_q) e_pc = br_target;
      OP_BNE: if (ra_q != rb_q) e_pc = br_target;
      OP_RET: begin
        mem_raddr = sp_inc;
        e_ret     = 1'b1;
        e_we      = 1'b1;
        e_waddr   = 2'd3;
        e_wdata   = sp_inc;
      end
      OP_NOT: begin e_we = 1'b1; e_wdata = ~rb_q; end
      default: ;
    endcase
  end

  // Gating on the state means an async reset before the execute edge suppresses the write.
  data_mem_sp #(.MEM_AW(MEM_AW)) u_mem (
    .clk   (clk),
    .we    (mem_we && (state == ST_EXEC)),
    .waddr (mem_waddr[MEM_AW-1:0]),
    .wdata (mem_wdata),
    .raddr (mem_raddr[MEM_AW-1:0]),
    .rdata (mem_rdata)
  );

  logic       s_we, s_ovf, s_halt, s_ld, s_ret;
  logic [1:0] s_waddr;
  logic [7:0] s_wdata, s_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_we    <= 1'b0;
      s_ovf   <= 1'b0;
      s_halt  <= 1'b0;
      s_ld    <= 1'b0;
      s_ret   <= 1'b0;
      s_waddr <= '0;
      s_wdata <= '0;
      s_pc    <= '0;
    end else if (state == ST_EXEC) begin
      s_we    <= e_we;
      s_ovf   <= e_ovf;
      s_halt  <= e_halt;
      s_ld    <= e_ld;
      s_ret   <= e_ret;
      s_waddr <= e_waddr;
      s_wdata <= e_wdata;
      s_pc    <= e_pc;
    end
  end

  // LW data and RET target only exist after the registered memory read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      pc_next   <= '0;
      overflow  <= 1'b0;
      halt      <= 1'b0;
    end else if (state == ST_WB) begin
      valid_out <= 1'b1;
      reg_we    <= s_we;
      reg_waddr <= s_waddr;
      reg_wdata <= s_ld ? mem_rdata : s_wdata;
      pc_next   <= s_ret ? mem_rdata : s_pc;
      overflow  <= s_ovf;
      halt      <= s_halt;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - self-checking bench for exec_unit with behavioural model
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready;
  logic [7:0] instr = 8'h00;
  logic [7:0] pc = 8'h00;
  logic [1:0] ra_addr, rb_addr;
  logic [7:0] ra_data = 8'h00, rb_data = 8'h00, r0_data = 8'h00, sp_data = 8'h00;
  logic       valid_out, reg_we, overflow, halt;
  logic [1:0] reg_waddr;
  logic [7:0] reg_wdata, pc_next;

  always #5 clk = ~clk;

  exec_unit #(.MEM_AW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready     (ready),
    .instr     (instr),
    .pc        (pc),
    .ra_addr   (ra_addr),
    .rb_addr   (rb_addr),
    .ra_data   (ra_data),
    .rb_data   (rb_data),
    .r0_data   (r0_data),
    .sp_data   (sp_data),
    .valid_out (valid_out),
    .reg_we    (reg_we),
    .reg_waddr (reg_waddr),
    .reg_wdata (reg_wdata),
    .pc_next   (pc_next),
    .overflow  (overflow),
    .halt      (halt)
  );

  typedef struct {
    bit       we;
    bit [1:0] wa;
    bit [7:0] wd;
    bit [7:0] pcn;
    bit       ovf;
    bit       halt;
  } exp_t;

  exp_t exp_q[$];
  exp_t got_e;
  int   tests = 0;
  int   fails = 0;
  int   n_exp = 0;
  int   n_out = 0;
  int   mdl_mem[256];
  int   regs[4];
  int   last_pcn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int to_s8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Architectural model: plain integer arithmetic over a model register file and memory.
  function automatic exp_t model_exec(input int i, input int p);
    exp_t e;
    int op, ra, rb, imm, simm, va, vb, sa, sb, r, sp;
    op   = i / 16;
    ra   = (i / 4) % 4;
    rb   = i % 4;
    imm  = i % 16;
    simm = (imm >= 8) ? imm - 16 : imm;
    va   = regs[ra];
    vb   = regs[rb];
    sa   = to_s8(va);
    sb   = to_s8(vb);
    sp   = regs[3];
    e    = '{default: 0};
    e.pcn = 8'((p + 1) % 256);
    e.wa  = 2'(ra);
    case (op)
      0:  begin e.halt = 1; e.pcn = 8'(p); end
      1:  begin r = sa + sb; e.we = 1; e.wd = 8'(r & 255); e.ovf = (r > 127 || r < -128); end
      2:  begin r = sa - sb; e.we = 1; e.wd = 8'(r & 255); e.ovf = (r > 127 || r < -128); end
      3:  begin e.we = 1; e.wd = 8'(va & vb); end
      4:  begin e.we = 1; e.wd = 8'(va | vb); end
      5:  begin e.we = 1; e.wd = 8'(va ^ vb); end
      6:  begin e.we = 1; e.wd = (sa < sb) ? 8'd1 : 8'd0; end
      7:  begin e.we = 1; e.wa = 2'd0; e.wd = 8'(imm); end
      8:  e.pcn = 8'((p + 1 + simm + 256) % 256);
      9:  begin
            mdl_mem[sp] = (p + 1) % 256;
            e.we = 1; e.wa = 2'd3; e.wd = 8'((sp + 255) % 256);
            e.pcn = 8'((p + 1 + simm + 256) % 256);
          end
      10: begin e.we = 1; e.wd = 8'(mdl_mem[vb]); end
      11: mdl_mem[vb] = va;
      12: if (va == vb) e.pcn = 8'((p + 1 + regs[0]) % 256);
      13: if (va != vb) e.pcn = 8'((p + 1 + regs[0]) % 256);
      14: begin
            e.we = 1; e.wa = 2'd3; e.wd = 8'((sp + 1) % 256);
            e.pcn = 8'(mdl_mem[(sp + 1) % 256]);
          end
      default: begin e.we = 1; e.wd = 8'(255 - vb); end
    endcase
    if (e.we) regs[e.wa] = int'(e.wd);
    return e;
  endfunction

  task automatic issue(input logic [7:0] i, input logic [7:0] p, input bit track);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", ready, 1);
    instr    = i;
    pc       = p;
    ra_data  = 8'(regs[i[3:2]]);
    rb_data  = 8'(regs[i[1:0]]);
    r0_data  = 8'(regs[0]);
    sp_data  = 8'(regs[3]);
    valid_in = 1'b1;
    #1;
    chk("ra_addr", ra_addr, i[3:2]);
    chk("rb_addr", rb_addr, i[1:0]);
    if (track) begin
      e = model_exec(int'(i), int'(p));
      last_pcn = int'(e.pcn);
      exp_q.push_back(e);
      n_exp++;
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!valid_out && lat < 10);
    chk("valid_out_seen", valid_out, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_valid_out"}, valid_out, 0);
    chk({tag, "_reg_we"}, reg_we, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_halt"}, halt, 0);
    chk({tag, "_reg_waddr"}, reg_waddr, 0);
    chk({tag, "_reg_wdata"}, reg_wdata, 0);
    chk({tag, "_pc_next"}, pc_next, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      n_out++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid_out: got valid_out=1 required 0");
      end else begin
        got_e = exp_q.pop_front();
        chk("m_pc_next", pc_next, got_e.pcn);
        chk("m_halt", halt, got_e.halt);
        chk("m_overflow", overflow, got_e.ovf);
        chk("m_reg_we", reg_we, got_e.we);
        if (got_e.we) begin
          chk("m_reg_waddr", reg_waddr, got_e.wa);
          chk("m_reg_wdata", reg_wdata, got_e.wd);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    regs = '{0, 0, 0, 0};
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;

    issue(8'h75, 8'h00, 1); wait_out(lat);
    chk("li_latency", lat, 3);
    chk("li_we", reg_we, 1);
    chk("li_waddr", reg_waddr, 0);
    chk("li_wdata", reg_wdata, 8'h05);
    chk("li_pc_next", pc_next, 8'h01);

    regs[1] = 8'h7F; regs[2] = 8'h01;
    issue(8'h16, 8'h01, 1); wait_out(lat);
    chk("add_wdata", reg_wdata, 8'h80);
    chk("add_ovf", overflow, 1);
    chk("add_waddr", reg_waddr, 1);

    regs[1] = 8'h80; regs[2] = 8'h01;
    issue(8'h26, 8'h02, 1); wait_out(lat);
    chk("sub_wdata", reg_wdata, 8'h7F);
    chk("sub_ovf", overflow, 1);

    regs[1] = 8'hFF; regs[2] = 8'h01;
    issue(8'h66, 8'h03, 1); wait_out(lat);
    chk("slt_wdata", reg_wdata, 8'h01);
    chk("slt_ovf", overflow, 0);

    regs[1] = 8'h5A; regs[2] = 8'h10;
    issue(8'hB6, 8'h04, 1); wait_out(lat);
    chk("sw_we", reg_we, 0);
    regs[1] = 8'h00; regs[2] = 8'h10;
    issue(8'hA6, 8'h05, 1); wait_out(lat);
    chk("lw_waddr", reg_waddr, 1);
    chk("lw_wdata", reg_wdata, 8'h5A);

    regs[0] = 8'h04; regs[1] = 8'h03; regs[2] = 8'h03;
    issue(8'hC6, 8'h10, 1); wait_out(lat);
    chk("beq_pc", pc_next, 8'h15);
    issue(8'hD6, 8'h10, 1); wait_out(lat);
    chk("bne_pc", pc_next, 8'h11);
    issue(8'h8E, 8'h10, 1); wait_out(lat);
    chk("j_pc", pc_next, 8'h0F);

    regs[3] = 8'hFF;
    issue(8'h93, 8'h20, 1); wait_out(lat);
    chk("jal_waddr", reg_waddr, 3);
    chk("jal_wdata", reg_wdata, 8'hFE);
    chk("jal_pc", pc_next, 8'h24);
    issue(8'hE0, 8'h24, 1); wait_out(lat);
    chk("ret_pc", pc_next, 8'h21);
    chk("ret_wdata", reg_wdata, 8'hFF);

    issue(8'h00, 8'h33, 1);
    valid_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 valid_in = 1'b0;
    wait_out(lat);
    chk("halt_flag", halt, 1);
    chk("halt_pc", pc_next, 8'h33);
    chk("halt_we", reg_we, 0);
    repeat (6) @(negedge clk);

    regs[1] = 8'hC3; regs[2] = 8'h10;
    issue(8'hB6, 8'h40, 0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outs("midop_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    regs[2] = 8'h10;
    issue(8'hA6, 8'h41, 1); wait_out(lat);
    chk("post_reset_lw", reg_wdata, 8'h5A);

    for (int a = 0; a < 256; a++) begin
      regs[1] = $urandom_range(0, 255);
      regs[2] = a;
      issue(8'hB6, 8'(last_pcn), 1);
    end

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int r = 0; r < 4; r++) regs[r] = $urandom_range(0, 255);
      end
      issue(8'($urandom_range(0, 255)), 8'(last_pcn), 1);
    end

    repeat (10) @(negedge clk);
    chk("pending_empty", exp_q.size(), 0);
    chk("pulse_count", n_out, n_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute/memory stage of the team's 8-bit, 4-register accumulator CPU.
- Combines instruction decode (control), ALU, branch/jump target computation and a 256x8 data memory.
- Accepts one decoded-from-fetch instruction plus register operands, and returns the register writeback and next PC.
- Sits between the register file/fetch logic and the writeback stage.

Parameters:
- MEM_AW, 8, data-memory address width; depth = 2**MEM_AW. Data width is fixed at 8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- valid_in  in  1  instruction/operands valid; accepted only when ready=1.
- ready  out  1  high when idle and able to accept.
- instr  in  8  instruction: opcode=instr[7:4], ra=instr[3:2], rb=instr[1:0], imm4=instr[3:0].
- pc  in  8  PC of the instruction.
- ra_addr  out  2  combinational = instr[3:2], for register-file read.
- rb_addr  out  2  combinational = instr[1:0].
- ra_data  in  8  value of reg[ra_addr], same cycle as valid_in.
- rb_data  in  8  value of reg[rb_addr], same cycle as valid_in.
- r0_data  in  8  value of reg0, used as the branch offset.
- sp_data  in  8  value of reg3, the stack pointer.
- valid_out  out  1  one-cycle pulse; result outputs valid.
- reg_we  out  1  register write enable, qualified by valid_out.
- reg_waddr  out  2  destination register.
- reg_wdata  out  8  destination data.
- pc_next  out  8  next PC.
- overflow  out  1  signed overflow of ADD/SUB.
- halt  out  1  HALT executed.

Behaviour:
- Reset: ready=1; valid_out, reg_we, overflow and halt =0; reg_waddr=0, reg_wdata=0, pc_next=0. Data memory is not cleared.
- Reset mid-operation aborts the operation; no memory write occurs after rst_n falls.
- Handshake and latency:
  - Edge T (valid_in&ready): capture instr, pc and all operands; ready drops.
  - Edge T+1: ALU, memory write and memory read occur.
  - Edge T+2: outputs registered; valid_out=1 for exactly one cycle; ready returns to 1 in that same cycle.
  - Throughput is one instruction per 3 cycles; valid_in while ready=0 is ignored.
- Outputs hold their last values while valid_out=0.
- Default next PC is pc+1 modulo 256; every PC sum wraps mod 256. Unless stated otherwise, overflow=0 and reg_we=0.
- Opcodes:
  - 0000 HALT: halt=1, pc_next=pc, no writes.
  - 0001 ADD: ra<=ra+rb. overflow = signed overflow.
  - 0010 SUB: ra<=ra-rb. overflow = signed overflow.
  - 0011 AND, 0100 OR, 0101 XOR: ra<=ra op rb.
  - 0110 SLT: ra<= (signed ra < signed rb) ? 1 : 0.
  - 0111 LI: r0<={4'b0,imm4}.
  - 1000 J: pc_next=pc+1+sext(imm4).
  - 1001 JAL: mem[sp]<=pc+1; r3<=sp-1; pc_next=pc+1+sext(imm4).
  - 1010 LW: ra<=mem[rb].
  - 1011 SW: mem[rb]<=ra; no register write.
  - 1100 BEQ: pc_next = pc+1+r0 if ra==rb, else pc+1.
  - 1101 BNE: pc_next = pc+1+r0 if ra!=rb, else pc+1.
  - 1110 RET: r3<=sp+1; pc_next=mem[sp+1].
  - 1111 NOT: ra<=~rb.
- When ra==rb, the captured operand values are used for both inputs.
- Stack pointer wraps mod 256: sp=0x00 RET reads mem[0x01]; sp=0x00 JAL writes r3=0xFF.
- Memory: synchronous write; registered read. A read of a just-written address returns the new data only in a later instruction.

Decomposition:
- Package exec_pkg: 4-bit opcode localparams (OP_HALT…OP_NOT), field bit positions, and a function sext4 returning 8 bits.
- Sub-module data_mem_sp (MEM_AW): 1 write/1 read synchronous RAM.
- Decode, ALU and next-PC logic stay inline.

Test Plan:
- Reset, then LI 0x75 (r0<=5) -> valid_out 3 cycles after accept; reg_we=1, reg_waddr=0, reg_wdata=0x05, pc_next=pc+1.
- ADD ra=0x7F, rb=0x01 -> reg_wdata=0x80, overflow=1. SUB 0x80-0x01 -> 0x7F, overflow=1. SLT 0xFF vs 0x01 -> 0x01.
- SW instr=0xB6 (ra=1, rb=2), ra=0x5A, rb=0x10 -> no reg write. Then LW instr=0xA6, rb=0x10 -> reg_waddr=1, reg_wdata=0x5A.
- BEQ ra=rb=3, r0=0x04, pc=0x10 -> pc_next=0x15. BNE with same operands -> 0x11. J imm4=0xE, pc=0x10 -> 0x0F.
- JAL imm4=3, pc=0x20, sp=0xFF -> r3<=0xFE, pc_next=0x24. Then RET with sp=0xFE -> pc_next=0x21, r3<=0xFF.
- valid_in held high while ready=0 -> no extra valid_out. Assert rst_n low during an SW -> memory unchanged, all outputs at reset values. HALT -> halt=1, pc_next=pc.
